// File: rtl/fifo_framer_pkg.sv
// Shared state encoding and header construction for the FIFO packet framer.
package fifo_framer_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        HDR,
        DATA,
        TRL
    } framer_state_t;

    localparam int HDR_W = 64;

    // Header carries the payload word count, zero-extended.
    function automatic logic [HDR_W-1:0] header_word(input int unsigned count);
        return HDR_W'(count);
    endfunction

endpackage

// File: rtl/framer_payload_buf.sv
// Payload register file: one synchronous write port, one asynchronous read port.
module framer_payload_buf #(
    parameter int width = 16,
    parameter int depth = 4,
    localparam int IW = $clog2((depth > 1) ? depth : 2)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [width-1:0] wr_data,
    input  logic [IW-1:0]    rd_idx,
    output logic [width-1:0] rd_data
);

    logic [width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fifo_pkt_framer.sv
// Drains a word FIFO into packets of header, payload and XOR trailer on a
// valid/ready stream; partial packets are flushed after an idle timeout.
module fifo_pkt_framer
    import fifo_framer_pkg::*;
#(
    parameter int width   = 16,
    parameter int pkt_len = 4,
    parameter int timeout = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] fifo_dout,
    input  logic             pndng,
    output logic             pop,
    output logic [width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sop,
    output logic             out_eop
);

    localparam int CW = $clog2(pkt_len + 1);
    localparam int IW = $clog2((pkt_len > 1) ? pkt_len : 2);
    localparam int TW = $clog2(timeout + 2);

    if (pkt_len < 1 || CW > width) begin : g_param_chk
        $error("fifo_pkt_framer: pkt_len must be >= 1 and its count must fit in width");
    end

    framer_state_t    state;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    rd;
    logic [TW-1:0]    idle;
    logic [TW-1:0]    idle_inc;
    logic [width-1:0] chk;
    logic [width-1:0] buf_word;
    logic             hs;
    logic             flush;

    assign hs       = out_valid & out_ready;
    assign idle_inc = idle + 1'b1;
    assign flush    = (timeout != 0) && (idle_inc == TW'(timeout));

    // Gating with rst keeps pop low for the whole reset window, not just after the next edge.
    assign pop = rst && (state == COLLECT) && pndng && (cnt < CW'(pkt_len));

    assign out_valid = (state != COLLECT);
    assign out_sop   = (state == HDR);
    assign out_eop   = (state == TRL);

    always_comb begin
        case (state)
            HDR:     out_data = width'(header_word(32'(cnt)));
            DATA:    out_data = buf_word;
            TRL:     out_data = chk;
            default: out_data = '0;
        endcase
    end

    framer_payload_buf #(
        .width(width),
        .depth(pkt_len)
    ) u_buf (
        .clk    (clk),
        .wr_en  (pop),
        .wr_idx (cnt[IW-1:0]),
        .wr_data(fifo_dout),
        .rd_idx (rd),
        .rd_data(buf_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= COLLECT;
            cnt   <= '0;
            rd    <= '0;
            idle  <= '0;
            chk   <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (pop) begin
                        cnt  <= cnt + 1'b1;
                        chk  <= chk ^ fifo_dout;
                        idle <= '0;
                        if (cnt == CW'(pkt_len - 1)) begin
                            state <= HDR;
                        end
                    end else if (cnt != '0) begin
                        // A pop on the expiry edge takes the branch above, so it always wins.
                        idle <= idle_inc;
                        if (flush) begin
                            state <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (hs) begin
                        rd    <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (hs) begin
                        rd <= rd + 1'b1;
                        if (CW'(rd) == cnt - 1'b1) begin
                            state <= TRL;
                        end
                    end
                end
                TRL: begin
                    if (hs) begin
                        cnt   <= '0;
                        chk   <= '0;
                        idle  <= '0;
                        state <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pkt_framer.sv
// Randomized and directed bench for fifo_pkt_framer against a queue-based packet model.
module tb_fifo_pkt_framer;

    localparam int W   = 16;
    localparam int PKT = 4;
    localparam int TMO = 16;

    typedef struct packed {
        logic [15:0] d;
        logic        s;
        logic        e;
    } sw_t;

    logic          clk;
    logic          rst;
    logic [W-1:0]  fifo_dout;
    logic          pndng;
    logic          pop;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sop;
    logic          out_eop;

    int checks = 0;
    int errors = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] pay_q[$];
    logic [15:0] pl_q[$];
    sw_t         emit_q[$];
    sw_t         got_q[$];
    sw_t         exp_q[$];
    int          idle_m = 0;
    int          n_pop = 0;
    logic        s_pop, s_valid;
    logic [15:0] s_data;

    fifo_pkt_framer #(
        .width  (W),
        .pkt_len(PKT),
        .timeout(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fifo_dout(fifo_dout),
        .pndng    (pndng),
        .pop      (pop),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sop  (out_sop),
        .out_eop  (out_eop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: a packet is header(count), payload, XOR of payload.
    task automatic build_pkt(ref logic [15:0] src[$], ref sw_t dst[$]);
        logic [15:0] x;
        x = '0;
        dst.push_back('{d: 16'(src.size()), s: 1'b1, e: 1'b0});
        foreach (src[i]) begin
            dst.push_back('{d: src[i], s: 1'b0, e: 1'b0});
            x = x ^ src[i];
        end
        dst.push_back('{d: x, s: 1'b0, e: 1'b1});
        src.delete();
    endtask

    // One clock cycle: drive FIFO view, check DUT against model, advance both.
    task automatic step();
        logic        exp_v, exp_pop, hs;
        logic [15:0] w;
        sw_t         cur;
        pndng     = (fifo_q.size() > 0);
        fifo_dout = pndng ? fifo_q[0] : 16'h0;
        #1;
        exp_v   = (emit_q.size() > 0);
        exp_pop = !exp_v && pndng && (pay_q.size() < PKT);
        check("pop", 32'(pop), 32'(exp_pop));
        check("valid", 32'(out_valid), 32'(exp_v));
        if (exp_v) begin
            check("data", 32'(out_data), 32'(emit_q[0].d));
            check("sop", 32'(out_sop), 32'(emit_q[0].s));
            check("eop", 32'(out_eop), 32'(emit_q[0].e));
        end
        s_pop   = pop;
        s_valid = out_valid;
        s_data  = out_data;
        hs      = out_valid && out_ready;
        cur     = '{d: out_data, s: out_sop, e: out_eop};
        w       = fifo_dout;
        @(posedge clk);
        if (s_pop) begin
            void'(fifo_q.pop_front());
            n_pop++;
        end
        if (hs) got_q.push_back(cur);
        if (exp_v) begin
            if (out_ready) void'(emit_q.pop_front());
        end else if (exp_pop) begin
            pay_q.push_back(w);
            idle_m = 0;
            if (pay_q.size() == PKT) build_pkt(pay_q, emit_q);
        end else if (pay_q.size() > 0) begin
            idle_m++;
            if (idle_m == TMO) begin
                build_pkt(pay_q, emit_q);
                idle_m = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_until(input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check("budget", 32'(got_q.size() >= n), 1);
    endtask

    task automatic cmp_stream(input string tag);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size()) check($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, n_push, n_data, thr;
        rst       = 1'b0;
        pndng     = 1'b1;
        fifo_dout = 16'h5555;
        out_ready = 1'b1;
        #3;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_sop", 32'(out_sop), 0);
        check("rst_eop", 32'(out_eop), 0);
        check("rst_pop", 32'(pop), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Full packet
        n_pop = 0;
        fifo_q = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
        pl_q   = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
        build_pkt(pl_q, exp_q);
        run_until(6, 40);
        check("full_hdr", 32'(got_q[0].d), 'h4);
        check("full_trl", 32'(got_q[5].d), 'hF);
        check("full_pops", 32'(n_pop), 4);
        cmp_stream("full");

        // Timeout flush
        n_pop = 0;
        fifo_q = '{16'h1234, 16'h00FF};
        gap = 0;
        for (int k = 0; k < 10 && n_pop < 2; k++) step();
        for (int k = 0; k < 40; k++) begin
            step();
            if (s_valid) break;
            gap++;
        end
        check("tmo_gap", 32'(gap), TMO);
        run_until(4, 20);
        check("tmo_hdr", 32'(got_q[0].d), 'h2);
        check("tmo_trl", 32'(got_q[3].d), 'h12CB);
        pl_q = '{16'h1234, 16'h00FF};
        build_pkt(pl_q, exp_q);
        cmp_stream("tmo");

        // Backpressure in DATA
        fifo_q = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4, 16'h00E5, 16'h00F6, 16'h0017, 16'h0028};
        run_until(2, 30);
        out_ready = 1'b0;
        step();
        check("bp_data0", 32'(s_data), 'hB2);
        check("bp_pop0", 32'(s_pop), 0);
        for (int k = 1; k < 5; k++) begin
            step();
            check("bp_hold_data", 32'(s_data), 'hB2);
            check("bp_hold_valid", 32'(s_valid), 1);
            check("bp_hold_pop", 32'(s_pop), 0);
        end
        out_ready = 1'b1;
        run_until(12, 40);
        pl_q = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4};
        build_pkt(pl_q, exp_q);
        pl_q = '{16'h00E5, 16'h00F6, 16'h0017, 16'h0028};
        build_pkt(pl_q, exp_q);
        cmp_stream("bp");

        // Continuous 12 words
        for (int i = 0; i < 12; i++) fifo_q.push_back(16'(i));
        run_until(18, 80);
        for (int p = 0; p < 3; p++) begin
            check("cont_hdr", 32'(got_q[6*p]), 32'({16'h0004, 2'b10}));
            for (int k = 0; k < 4; k++)
                check("cont_pay", 32'(got_q[6*p+1+k].d), 32'(4*p + k));
            check("cont_trl", 32'(got_q[6*p+5]), 32'({16'h0000, 2'b01}));
        end
        got_q.delete();

        // Reset mid-DATA
        fifo_q = '{16'h0011, 16'h0022, 16'h0044, 16'h0088, 16'h0101, 16'h0202, 16'h0303, 16'h0404};
        run_until(3, 30);
        check("rst_pre_valid", 32'(s_valid), 1);
        pndng     = (fifo_q.size() > 0);
        fifo_dout = fifo_q[0];
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid), 0);
        check("rst_mid_data", 32'(out_data), 0);
        check("rst_mid_sop", 32'(out_sop), 0);
        check("rst_mid_eop", 32'(out_eop), 0);
        check("rst_mid_pop", 32'(pop), 0);
        @(negedge clk);
        pay_q.delete();
        emit_q.delete();
        got_q.delete();
        idle_m = 0;
        rst = 1'b1;
        run_until(6, 40);
        pl_q = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        build_pkt(pl_q, exp_q);
        cmp_stream("rst");

        // Pop on the would-be expiry edge
        n_pop = 0;
        fifo_q.push_back(16'h0AAA);
        for (int k = 0; k < 10 && n_pop < 1; k++) step();
        for (int k = 0; k < TMO - 1; k++) step();
        check("race_quiet", 32'(s_valid), 0);
        fifo_q.push_back(16'h0555);
        step();
        check("race_pop", 32'(s_pop), 1);
        run_until(4, 40);
        check("race_hdr", 32'(got_q[0].d), 'h2);
        check("race_trl", 32'(got_q[3].d), 'h0FFF);
        got_q.delete();

        // Randomized traffic and backpressure
        n_push = 0;
        for (int c = 0; c < 3000; c++) begin
            thr = (((c / 400) % 2) == 0) ? 4 : 1;
            if (fifo_q.size() < 8 && $urandom_range(0, 19) < thr) begin
                fifo_q.push_back(16'($urandom));
                n_push++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) step();
        n_data = 0;
        foreach (got_q[i]) if (!got_q[i].s && !got_q[i].e) n_data++;
        check("rand_words", 32'(n_data), 32'(n_push));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_pkt_framer.md
# fifo_pkt_framer

Downstream consumer of the `fifo_flops` word FIFO. It drains words through the FIFO's `pop`/`pndng` interface and groups them into packets of up to `pkt_len` payload words. Each packet is emitted as a header word, the buffered payload, and an XOR checksum trailer on a valid/ready stream. A partial packet is flushed when the FIFO stays empty for `timeout` cycles.

## Interface
- `width`, 16: word width; must equal the FIFO `bits`.
- `pkt_len`, 4: maximum payload words per packet (≥1).
- `timeout`, 16: idle cycles before a partial packet is flushed; 0 disables flushing.

- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `fifo_dout`  in  width  FIFO head word, valid while `pndng`=1.
- `pndng`  in  1  FIFO non-empty.
- `pop`  out  1  consume FIFO head at this rising edge.
- `out_data`  out  width  stream word.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  sink accepts the word at this edge.
- `out_sop`  out  1  marks the header word.
- `out_eop`  out  1  marks the trailer word.

## Operation
- States: COLLECT, HDR, DATA, TRL. Reset state is COLLECT, with cnt=0, idle=0 and chk=0.
- COLLECT:
  - `pop` = `pndng` & (cnt<pkt_len) & `rst`. This is combinational and forced to 0 in every other state and during reset.
  - On a pop edge: buf[cnt]←`fifo_dout`, cnt++, chk←chk^`fifo_dout`, idle←0.
  - When cnt>0 and there is no pop, idle++. cnt=0 holds idle at 0.
  - Go to HDR at the edge where cnt reaches pkt_len.
  - Also go to HDR at the edge where idle would reach `timeout` (timeout≠0, cnt>0).
- HDR:
  - `out_data` = cnt zero-extended to width; `out_sop`=1.
  - On `out_valid`&`out_ready`: rd←0, go to DATA.
- DATA:
  - `out_data` = buf[rd].
  - On handshake: rd++. Go to TRL after word cnt-1 is accepted.
- TRL:
  - `out_data` = chk; `out_eop`=1.
  - On handshake: cnt←0, chk←0, idle←0, go to COLLECT.
- Stream rules:
  - `out_valid`=1 in HDR, DATA and TRL; 0 in COLLECT.
  - While `out_valid`=1 and `out_ready`=0, `out_data`/`out_sop`/`out_eop` hold stable.
- Width rule: $clog2(pkt_len+1) ≤ width (elaboration assertion). The checksum is a plain bitwise XOR over width bits.
- No popping while emitting. The FIFO absorbs upstream traffic and may go full; this is legal.
- Reset mid-packet: the buffered words are discarded, outputs drop immediately, and no partial trailer is emitted.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_sop`=0, `out_eop`=0, `pop`=0.
- Outputs other than `pop` are registered/state-decoded; `pop` is combinational from `pndng`.
- A full packet with `pndng` steady and `out_ready`=1 takes:
  - pkt_len pop cycles;
  - the header valid in the next cycle;
  - then one word per cycle, pkt_len+2 cycles total on the stream.
- Earliest next pop is the cycle after the trailer handshake.
- Timeout flush: the last pop is followed by exactly `timeout` idle cycles in COLLECT, then HDR.
- `pndng` returning on the same edge that idle would hit `timeout` means the pop wins: idle resets and there is no flush.

## Structure
- Package `fifo_framer_pkg` holds:
  - the state enum (COLLECT/HDR/DATA/TRL);
  - a function building the header word from cnt.
- Sub-module `framer_payload_buf`: pkt_len×width register file with a write port (wr_en, wr_idx, wr_data) and an async read (rd_idx). It has no reset, since its contents are don't-care until written.
- Top module holds the FSM, cnt/rd/idle counters and the checksum register.

## Test plan
- Full packet, pkt_len=4: FIFO loaded with 0x0001, 0x0002, 0x0004, 0x0008, `out_ready`=1.
  - Stream: 0x0004(sop), 0x0001, 0x0002, 0x0004, 0x0008, 0x000F(eop).
  - `pop` high exactly 4 cycles.
- Timeout flush, timeout=16: push 0x1234 and 0x00FF, then nothing.
  - Header 0x0002 appears 16 cycles after the second pop.
  - Then 0x1234, 0x00FF, trailer 0x12CB.
- Backpressure: hold `out_ready`=0 for 5 cycles during DATA.
  - `out_data`/`out_valid` stay stable; `pop` stays 0.
  - No word is lost or duplicated after release.
- Continuous 12 words 0x0000..0x000B:
  - three packets, each header 0x0004.
  - Trailers 0x0000, 0x0000, 0x0000 (XOR of each group of 4 consecutive values starting at a multiple of 4 is 0).
- Reset asserted mid-DATA: all outputs 0 asynchronously. After release, the next 4 FIFO words form a fresh packet with a correct checksum.
- pndng arriving on the same edge the timeout would expire (cnt=1): the pop occurs, there is no flush, and cnt becomes 2.
